// File: rtl/csr_regfile_pkg.sv
// Shared CSR address map, mstatus bit positions and mcause codes for the
// machine-mode register file and the interrupt controller.
package csr_regfile_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

    localparam logic [31:0] MCAUSE_ECALL_M      = 32'h0000_000B;
    localparam logic [31:0] MCAUSE_TIMER_IRQ    = 32'h8000_0007;
    localparam logic [31:0] MCAUSE_EXTERNAL_IRQ = 32'h8000_000B;

    // MPP is hardwired to machine mode; only MIE/MPIE carry state.
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] v;
        v = 32'h0000_1800;
        v[MSTATUS_MIE_BIT]  = mie;
        v[MSTATUS_MPIE_BIT] = mpie;
        return v;
    endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// CSR access bus between the requesters (ex stage, clint) and the register file.
interface csr_regfile_if;

    logic        ex_we;
    logic [11:0] ex_waddr;
    logic [31:0] ex_wdata;
    logic [11:0] ex_raddr;
    logic [31:0] ex_rdata;
    logic        clint_we;
    logic [11:0] clint_waddr;
    logic [31:0] clint_wdata;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic [31:0] csr_mstatus;
    logic        global_interrupt_enable;
    logic        irq_pending;

    modport master (
        output ex_we, ex_waddr, ex_wdata, ex_raddr,
        output clint_we, clint_waddr, clint_wdata,
        input  ex_rdata, csr_mtvec, csr_mepc, csr_mstatus,
        input  global_interrupt_enable, irq_pending
    );

    modport slave (
        input  ex_we, ex_waddr, ex_wdata, ex_raddr,
        input  clint_we, clint_waddr, clint_wdata,
        output ex_rdata, csr_mtvec, csr_mepc, csr_mstatus,
        output global_interrupt_enable, irq_pending
    );

endinterface

// File: rtl/csr_regfile_counter64.sv
// 64-bit free-running counter with per-half write; a write to either half
// suppresses that cycle's increment for the whole counter.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] value_q;
    logic [63:0] value_d;

    always_comb begin
        value_d = value_q;
        if (we_lo) begin
            value_d = {value_q[63:32], wdata};
        end else if (we_hi) begin
            value_d = {wdata, value_q[31:0]};
        end else if (inc) begin
            value_d = value_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: ex/clint write ports, combinational read
// port, mcycle/minstret counters and interrupt-pending view for clint.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instret,
    input  logic         irq_timer,
    input  logic         irq_external,
    csr_regfile_if.slave bus
);

    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [31:0] mstatus;
    logic [31:0] mip;

    // clint owns the write port whenever it drives; the ex write is dropped.
    assign wr_en   = bus.clint_we | bus.ex_we;
    assign wr_addr = bus.clint_we ? bus.clint_waddr : bus.ex_waddr;
    assign wr_data = bus.clint_we ? bus.clint_wdata : bus.ex_wdata;

    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (wr_en) begin
            case (wr_addr)
                CSR_MSTATUS: begin
                    mst_mie_d  = wr_data[MSTATUS_MIE_BIT];
                    mst_mpie_d = wr_data[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = wr_data & MIE_WMASK;
                CSR_MTVEC:    mtvec_d    = {wr_data[31:2], 2'b00};
                CSR_MSCRATCH: mscratch_d = wr_data;
                CSR_MEPC:     mepc_d     = {wr_data[31:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .we_lo (wr_en && (wr_addr == CSR_MCYCLE)),
        .we_hi (wr_en && (wr_addr == CSR_MCYCLEH)),
        .wdata (wr_data),
        .value (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (instret),
        .we_lo (wr_en && (wr_addr == CSR_MINSTRET)),
        .we_hi (wr_en && (wr_addr == CSR_MINSTRETH)),
        .wdata (wr_data),
        .value (minstret)
    );

    assign mstatus = mstatus_pack(mst_mie_q, mst_mpie_q);
    assign mip     = {20'b0, irq_external, 3'b0, irq_timer, 7'b0};

    always_comb begin
        bus.ex_rdata = '0;
        case (bus.ex_raddr)
            CSR_MSTATUS:   bus.ex_rdata = mstatus;
            CSR_MISA:      bus.ex_rdata = MISA_VALUE;
            CSR_MIE:       bus.ex_rdata = mie_q;
            CSR_MTVEC:     bus.ex_rdata = mtvec_q;
            CSR_MSCRATCH:  bus.ex_rdata = mscratch_q;
            CSR_MEPC:      bus.ex_rdata = mepc_q;
            CSR_MCAUSE:    bus.ex_rdata = mcause_q;
            CSR_MIP:       bus.ex_rdata = mip;
            CSR_MCYCLE:    bus.ex_rdata = mcycle[31:0];
            CSR_MINSTRET:  bus.ex_rdata = minstret[31:0];
            CSR_MCYCLEH:   bus.ex_rdata = mcycle[63:32];
            CSR_MINSTRETH: bus.ex_rdata = minstret[63:32];
            CSR_MHARTID:   bus.ex_rdata = HART_ID;
            default: ;
        endcase
    end

    assign bus.csr_mtvec               = mtvec_q;
    assign bus.csr_mepc                = mepc_q;
    assign bus.csr_mstatus             = mstatus;
    assign bus.global_interrupt_enable = mst_mie_q;
    assign bus.irq_pending             = mst_mie_q & |(mie_q & mip);

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: reset values, field masks, write priority,
// counter carry/write precedence, interrupt pending and asynchronous reset.
module tb_csr_regfile;

    logic clk = 1'b0;
    logic rst_n;
    logic instret;
    logic irq_timer;
    logic irq_external;

    int checks = 0;
    int errors = 0;

    csr_regfile_if bus ();

    csr_regfile #(
        .HART_ID     (32'h0),
        .MISA_VALUE  (32'h4000_0100),
        .MTVEC_RESET (32'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instret      (instret),
        .irq_timer    (irq_timer),
        .irq_external (irq_external),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] data);
        bus.ex_raddr = addr;
        #1;
        data = bus.ex_rdata;
    endtask

    task automatic ex_wr(input logic [11:0] addr, input logic [31:0] data);
        bus.ex_we    = 1'b1;
        bus.ex_waddr = addr;
        bus.ex_wdata = data;
        tick();
        bus.ex_we    = 1'b0;
    endtask

    task automatic clint_wr(input logic [11:0] addr, input logic [31:0] data);
        bus.clint_we    = 1'b1;
        bus.clint_waddr = addr;
        bus.clint_wdata = data;
        tick();
        bus.clint_we    = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] r2;
        rst_n            = 1'b0;
        instret          = 1'b0;
        irq_timer        = 1'b0;
        irq_external     = 1'b0;
        bus.ex_we        = 1'b0;
        bus.ex_waddr     = '0;
        bus.ex_wdata     = '0;
        bus.ex_raddr     = '0;
        bus.clint_we     = 1'b0;
        bus.clint_waddr  = '0;
        bus.clint_wdata  = '0;

        #12;
        check("rst_mstatus", bus.csr_mstatus, 32'h0000_1800);
        check("rst_mtvec", bus.csr_mtvec, 32'h0);
        check("rst_mepc", bus.csr_mepc, 32'h0);
        check("rst_gie", {31'b0, bus.global_interrupt_enable}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Test 1: reads after reset release
        rd(12'h300, r); check("rd_mstatus", r, 32'h0000_1800);
        rd(12'h305, r); check("rd_mtvec", r, 32'h0);
        rd(12'hF14, r); check("rd_mhartid", r, 32'h0);
        rd(12'h301, r); check("rd_misa", r, 32'h4000_0100);
        rd(12'h7C0, r); check("rd_unimpl", r, 32'h0);

        // Test 2: mstatus write mask
        ex_wr(12'h300, 32'hFFFF_FFFF);
        check("mstatus_all1", bus.csr_mstatus, 32'h0000_1888);
        check("gie_set", {31'b0, bus.global_interrupt_enable}, 32'h1);
        rd(12'h300, r); check("rd_mstatus_all1", r, 32'h0000_1888);

        ex_wr(12'h304, 32'hFFFF_FFFF);
        rd(12'h304, r); check("mie_mask", r, 32'h0000_0888);
        ex_wr(12'h305, 32'h0000_1003);
        check("mtvec_align", bus.csr_mtvec, 32'h0000_1000);
        ex_wr(12'h301, 32'h0);
        rd(12'h301, r); check("misa_ro", r, 32'h4000_0100);
        ex_wr(12'hF14, 32'h5);
        rd(12'hF14, r); check("mhartid_ro", r, 32'h0);
        ex_wr(12'h344, 32'hFFFF_FFFF);
        rd(12'h344, r); check("mip_ro", r, 32'h0);
        ex_wr(12'h7C0, 32'h1234_5678);
        rd(12'h7C0, r); check("unimpl_wr", r, 32'h0);

        // Test 3: trap entry sequence from clint
        clint_wr(12'h341, 32'h0000_1236);
        check("trap_mepc", bus.csr_mepc, 32'h0000_1234);
        clint_wr(12'h300, 32'h0000_1880);
        check("trap_mstatus", bus.csr_mstatus, 32'h0000_1880);
        check("trap_gie", {31'b0, bus.global_interrupt_enable}, 32'h0);
        clint_wr(12'h342, 32'h8000_0007);
        rd(12'h342, r); check("trap_mcause", r, 32'h8000_0007);

        // Test 4: simultaneous writes, clint wins
        bus.ex_we = 1'b1; bus.ex_waddr = 12'h340; bus.ex_wdata = 32'hB;
        clint_wr(12'h340, 32'hA);
        bus.ex_we = 1'b0;
        rd(12'h340, r); check("prio_same_addr", r, 32'hA);
        bus.ex_we = 1'b1; bus.ex_waddr = 12'h305; bus.ex_wdata = 32'h100;
        clint_wr(12'h340, 32'h5);
        bus.ex_we = 1'b0;
        check("prio_ex_dropped", bus.csr_mtvec, 32'h0000_1000);
        rd(12'h340, r); check("prio_clint_diff", r, 32'h5);

        // Test 5: mcycle carry and write precedence
        ex_wr(12'hB80, 32'h0);
        ex_wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, r); rd(12'hB80, r2);
        check("mcycle_wr_lo", r, 32'hFFFF_FFFF);
        check("mcycle_wr_hi", r2, 32'h0);
        tick();
        rd(12'hB00, r); rd(12'hB80, r2);
        check("mcycle_carry_lo", r, 32'h0);
        check("mcycle_carry_hi", r2, 32'h1);
        tick();
        rd(12'hB00, r); rd(12'hB80, r2);
        check("mcycle_lo_2", r, 32'h1);
        check("mcycle_hi_2", r2, 32'h1);

        instret = 1'b1;
        tick(); tick(); tick();
        instret = 1'b0;
        rd(12'hB02, r); rd(12'hB82, r2);
        check("minstret_lo", r, 32'h3);
        check("minstret_hi", r2, 32'h0);

        // Test 6: interrupt pending, then asynchronous reset mid-trap
        ex_wr(12'h304, 32'h0000_0080);
        ex_wr(12'h300, 32'h0000_0008);
        check("irq_idle", {31'b0, bus.irq_pending}, 32'h0);
        irq_timer = 1'b1;
        #1;
        check("irq_timer_pend", {31'b0, bus.irq_pending}, 32'h1);
        rd(12'h344, r); check("mip_mtip", r, 32'h0000_0080);
        irq_external = 1'b1;
        rd(12'h344, r); check("mip_both", r, 32'h0000_0880);
        irq_external = 1'b0;

        clint_wr(12'h341, 32'h0000_2000);
        check("mid_mepc", bus.csr_mepc, 32'h0000_2000);
        bus.clint_we = 1'b1; bus.clint_waddr = 12'h300; bus.clint_wdata = 32'h0000_1880;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mstatus", bus.csr_mstatus, 32'h0000_1800);
        check("arst_mepc", bus.csr_mepc, 32'h0);
        check("arst_mtvec", bus.csr_mtvec, 32'h0);
        check("arst_gie", {31'b0, bus.global_interrupt_enable}, 32'h0);
        check("arst_irq", {31'b0, bus.irq_pending}, 32'h0);
        rd(12'h342, r); check("arst_mcause", r, 32'h0);
        rd(12'hB80, r); check("arst_mcycleh", r, 32'h0);
        bus.clint_we = 1'b0;
        irq_timer = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
